// File: rtl/fwd_unit.sv
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Owns the EX/MEM and MEM/WB registers and drives the register-file write port.
module fwd_unit #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_rs1,
    input  logic [REG_W-1:0]  ex_rs2,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        cntrl_sign1,
    output logic [1:0]        cntrl_sign2,
    output logic [DATA_W-1:0] fwd_val1,
    output logic [DATA_W-1:0] fwd_val2,
    output logic              stall,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b10;
    localparam logic [1:0] SEL_MWB = 2'b11;

    // EX/MEM pipeline register
    logic              r_exm_valid;
    logic [REG_W-1:0]  r_exm_rd;
    logic              r_exm_reg_write;
    logic              r_exm_mem_read;
    logic [DATA_W-1:0] r_exm_result;

    // MEM/WB pipeline register
    logic              r_mwb_valid;
    logic [REG_W-1:0]  r_mwb_rd;
    logic              r_mwb_reg_write;
    logic [DATA_W-1:0] r_mwb_data;

    logic [15:0]       r_stall_count;

    logic [2*REG_W-1:0]  w_rs_all;
    logic [1:0]          w_exm_hit;
    logic [1:0]          w_mwb_hit;
    logic [1:0]          w_load_hit;
    logic [3:0]          w_sel;
    logic [2*DATA_W-1:0] w_val;
    logic                w_stall;

    assign w_rs_all = {ex_rs2, ex_rs1};

    // A load in EX/MEM cannot be forwarded yet; hold the consumer for one cycle.
    assign w_stall = ex_valid & (|w_load_hit);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [REG_W-1:0] w_rs;

            assign w_rs = w_rs_all[gi*REG_W +: REG_W];

            assign w_exm_hit[gi]  = r_exm_valid & r_exm_reg_write &
                                    (r_exm_rd == w_rs) & (r_exm_rd != '0);
            assign w_mwb_hit[gi]  = r_mwb_valid & r_mwb_reg_write &
                                    (r_mwb_rd == w_rs) & (r_mwb_rd != '0);
            assign w_load_hit[gi] = w_exm_hit[gi] & r_exm_mem_read;

            // While stalled the hazardous operand must not pick up an older MEM/WB copy.
            assign w_sel[gi*2 +: 2] =
                (w_exm_hit[gi] && !r_exm_mem_read) ? SEL_EXM :
                (w_load_hit[gi] && w_stall)        ? SEL_RF  :
                w_mwb_hit[gi]                      ? SEL_MWB :
                                                     SEL_RF;

            assign w_val[gi*DATA_W +: DATA_W] =
                (w_sel[gi*2 +: 2] == SEL_EXM) ? r_exm_result :
                (w_sel[gi*2 +: 2] == SEL_MWB) ? r_mwb_data   :
                                                '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exm_valid     <= 1'b0;
            r_exm_rd        <= '0;
            r_exm_reg_write <= 1'b0;
            r_exm_mem_read  <= 1'b0;
            r_exm_result    <= '0;
            r_mwb_valid     <= 1'b0;
            r_mwb_rd        <= '0;
            r_mwb_reg_write <= 1'b0;
            r_mwb_data      <= '0;
            r_stall_count   <= '0;
        end else begin
            if (w_stall) begin
                r_exm_valid     <= 1'b0;
                r_exm_rd        <= '0;
                r_exm_reg_write <= 1'b0;
                r_exm_mem_read  <= 1'b0;
                r_exm_result    <= '0;
            end else begin
                r_exm_valid     <= ex_valid;
                r_exm_rd        <= ex_rd;
                r_exm_reg_write <= ex_reg_write;
                r_exm_mem_read  <= ex_mem_read;
                r_exm_result    <= ex_result;
            end

            r_mwb_valid     <= r_exm_valid;
            r_mwb_rd        <= r_exm_rd;
            r_mwb_reg_write <= r_exm_reg_write;
            r_mwb_data      <= r_exm_mem_read ? mem_rdata : r_exm_result;

            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign cntrl_sign1  = w_sel[1:0];
    assign cntrl_sign2  = w_sel[3:2];
    assign fwd_val1     = w_val[DATA_W-1:0];
    assign fwd_val2     = w_val[2*DATA_W-1:DATA_W];
    assign stall        = w_stall;
    assign mem_addr     = r_exm_result;
    assign mem_rd_en    = r_exm_valid & r_exm_mem_read;
    assign wb_rd        = r_mwb_rd;
    assign wb_reg_write = r_mwb_valid & r_mwb_reg_write;
    assign wb_data      = r_mwb_data;
    assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_fwd_unit.sv
// Bench for fwd_unit: directed vector table, reset-during-stall sequence,
// and randomized traffic checked against an in-flight-instruction model.
module tb_fwd_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex_valid = 1'b0;
    logic [4:0] ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
    logic       ex_reg_write = 1'b0, ex_mem_read = 1'b0;
    logic [7:0] ex_result = '0, mem_rdata = '0;
    logic [1:0] cntrl_sign1, cntrl_sign2;
    logic [7:0] fwd_val1, fwd_val2, mem_addr, wb_data;
    logic       stall, mem_rd_en, wb_reg_write;
    logic [4:0] wb_rd;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    fwd_unit #(.DATA_W(8), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_result(ex_result), .mem_rdata(mem_rdata),
        .cntrl_sign1(cntrl_sign1), .cntrl_sign2(cntrl_sign2),
        .fwd_val1(fwd_val1), .fwd_val2(fwd_val2), .stall(stall),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic v; logic [4:0] rs1, rs2, rd; logic we, mr;
        logic [7:0] res, rdata;
        logic [1:0] c1, c2; logic [7:0] f1, f2; logic st, mre;
        logic wbwe; logic [4:0] wbrd; logic [7:0] wbd; logic chkwb;
        logic [15:0] sc;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs1, rs2, rd, input logic we, mr,
        input logic [7:0] res, rdata, input logic [1:0] c1, c2,
        input logic [7:0] f1, f2, input logic st, mre, wbwe,
        input logic [4:0] wbrd, input logic [7:0] wbd, input logic chkwb,
        input logic [15:0] sc);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.we = we; t.mr = mr;
        t.res = res; t.rdata = rdata; t.c1 = c1; t.c2 = c2; t.f1 = f1; t.f2 = f2;
        t.st = st; t.mre = mre; t.wbwe = wbwe; t.wbrd = wbrd; t.wbd = wbd;
        t.chkwb = chkwb; t.sc = sc;
        return t;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic v; logic [4:0] rd; logic we; logic ld; logic [7:0] val;
    } slot_t;

    slot_t exm_m, mwb_m;
    int    cnt_m;

    function automatic logic m_writes(input slot_t s, input logic [4:0] rs);
        return s.v && s.we && (s.rd == rs) && (rs != 5'd0);
    endfunction

    function automatic logic m_stall();
        return ex_valid && exm_m.ld &&
               (m_writes(exm_m, ex_rs1) || m_writes(exm_m, ex_rs2));
    endfunction

    // Youngest in-flight producer wins; a load still in EX/MEM has no value yet.
    function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic st);
        if (m_writes(exm_m, rs)) begin
            if (!exm_m.ld) return 2'b10;
            if (st) return 2'b00;
        end
        if (m_writes(mwb_m, rs)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [7:0] m_val(input logic [1:0] sel);
        if (sel == 2'b10) return exm_m.val;
        if (sel == 2'b11) return mwb_m.val;
        return 8'h00;
    endfunction

    task automatic m_clock(input logic st);
        mwb_m = exm_m;
        if (exm_m.ld) mwb_m.val = mem_rdata;
        if (st) exm_m = '0;
        else begin
            exm_m.v = ex_valid; exm_m.rd = ex_rd; exm_m.we = ex_reg_write;
            exm_m.ld = ex_mem_read; exm_m.val = ex_result;
        end
        if (st && cnt_m < 65535) cnt_m++;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, rs2, rd,
                         input logic we, mr, input logic [7:0] res, rdata);
        ex_valid = v; ex_rs1 = rs1; ex_rs2 = rs2; ex_rd = rd;
        ex_reg_write = we; ex_mem_read = mr; ex_result = res; mem_rdata = rdata;
    endtask

    vec_t tbl [14];

    initial begin
        logic [1:0] s1, s2;
        logic       st, hold;

        tbl[0]  = mk(1,1,2,3,1,0,8'h2A,8'h00, 0,0,8'h00,8'h00, 0,0, 0,0,8'h00,1, 0);
        tbl[1]  = mk(1,3,0,4,1,0,8'h11,8'h00, 2,0,8'h2A,8'h00, 0,0, 0,0,8'h00,1, 0);
        tbl[2]  = mk(1,1,2,7,0,0,8'h55,8'h00, 0,0,8'h00,8'h00, 0,0, 1,3,8'h2A,1, 0);
        tbl[3]  = mk(1,1,4,5,1,0,8'h01,8'h00, 0,3,8'h00,8'h11, 0,0, 1,4,8'h11,1, 0);
        tbl[4]  = mk(1,2,2,5,1,0,8'h02,8'h00, 0,0,8'h00,8'h00, 0,0, 0,7,8'h55,1, 0);
        tbl[5]  = mk(1,5,5,6,1,1,8'h40,8'h00, 2,2,8'h02,8'h02, 0,0, 1,5,8'h01,1, 0);
        tbl[6]  = mk(1,6,1,8,1,0,8'h33,8'h7F, 0,0,8'h00,8'h00, 1,1, 1,5,8'h02,1, 0);
        tbl[7]  = mk(1,6,1,8,1,0,8'h33,8'h00, 3,0,8'h7F,8'h00, 0,0, 1,6,8'h7F,1, 1);
        tbl[8]  = mk(1,0,0,0,1,0,8'hFF,8'h00, 0,0,8'h00,8'h00, 0,0, 0,0,8'h00,0, 1);
        tbl[9]  = mk(1,0,8,9,0,0,8'h00,8'h00, 0,3,8'h00,8'h33, 0,0, 1,8,8'h33,1, 1);
        tbl[10] = mk(1,0,0,0,1,1,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0, 1,0,8'hFF,1, 1);
        tbl[11] = mk(1,0,0,2,1,1,8'h20,8'h99, 0,0,8'h00,8'h00, 0,1, 0,9,8'h00,1, 1);
        tbl[12] = mk(0,2,2,0,0,0,8'h00,8'h5A, 0,0,8'h00,8'h00, 0,1, 1,0,8'h99,1, 1);
        tbl[13] = mk(1,2,3,1,0,0,8'h00,8'h00, 3,0,8'h5A,8'h00, 0,0, 1,2,8'h5A,1, 1);

        // Reset with a would-be hazard pattern on the inputs.
        drive(1, 6, 6, 6, 1, 1, 8'hAA, 8'hBB);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_c1", cntrl_sign1, 2'b00);
        chk("rst_c2", cntrl_sign2, 2'b00);
        chk("rst_f1", fwd_val1, 8'h00);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mre", mem_rd_en, 1'b0);
        chk("rst_wbwe", wb_reg_write, 1'b0);
        chk("rst_cnt", stall_count, 16'd0);
        $display("reset: stall=%0d mem_rd_en=%0d wb_reg_write=%0d", stall, mem_rd_en, wb_reg_write);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        chk("postrst_stall", stall, 1'b0);
        chk("postrst_c2", cntrl_sign2, 2'b00);
        chk("postrst_f2", fwd_val2, 8'h00);
        @(posedge clk); #1;

        // Directed table: each row is one EX-stage instruction.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].mr,
                  tbl[i].res, tbl[i].rdata);
            #3;
            $display("vec %0d: c1=%b c2=%b f1=%h f2=%h stall=%0d wb=%0d/%0d/%h cnt=%0d",
                     i, cntrl_sign1, cntrl_sign2, fwd_val1, fwd_val2, stall,
                     wb_reg_write, wb_rd, wb_data, stall_count);
            chk($sformatf("vec%0d_c1", i), cntrl_sign1, tbl[i].c1);
            chk($sformatf("vec%0d_c2", i), cntrl_sign2, tbl[i].c2);
            chk($sformatf("vec%0d_f1", i), fwd_val1, tbl[i].f1);
            chk($sformatf("vec%0d_f2", i), fwd_val2, tbl[i].f2);
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].st);
            chk($sformatf("vec%0d_mre", i), mem_rd_en, tbl[i].mre);
            chk($sformatf("vec%0d_wbwe", i), wb_reg_write, tbl[i].wbwe);
            chk($sformatf("vec%0d_cnt", i), stall_count, tbl[i].sc);
            if (tbl[i].chkwb) begin
                chk($sformatf("vec%0d_wbrd", i), wb_rd, tbl[i].wbrd);
                chk($sformatf("vec%0d_wbd", i), wb_data, tbl[i].wbd);
            end
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a stall cycle.
        drive(1, 0, 0, 6, 1, 1, 8'h44, 8'h00);
        @(posedge clk); #1;
        drive(1, 6, 0, 9, 1, 0, 8'h01, 8'h3C);
        #1;
        chk("midrst_pre_stall", stall, 1'b1);
        chk("midrst_pre_mre", mem_rd_en, 1'b1);
        chk("midrst_pre_c1", cntrl_sign1, 2'b00);
        rst = 1'b1;
        #1;
        $display("reset mid-stall: stall=%0d mem_rd_en=%0d wb_reg_write=%0d cnt=%0d",
                 stall, mem_rd_en, wb_reg_write, stall_count);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_mre", mem_rd_en, 1'b0);
        chk("midrst_wbwe", wb_reg_write, 1'b0);
        chk("midrst_cnt", stall_count, 16'd0);
        chk("midrst_c1", cntrl_sign1, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        exm_m = '0; mwb_m = '0; cnt_m = 0;
        #1;
        // Pending load was discarded: nothing to forward for rs1=x6.
        chk("postmid_c1", cntrl_sign1, 2'b00);
        @(posedge clk); #1;
        m_clock(1'b0);

        // Randomized traffic; stalled instructions are held like the real front end would.
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                drive(5'($urandom_range(0, 9)) < 5'd8,
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 9)) < 5'd7,
                      5'($urandom_range(0, 9)) < 5'd3,
                      8'($urandom), 8'($urandom));
            end else begin
                mem_rdata = 8'($urandom);
            end
            #3;
            st = m_stall();
            s1 = m_sel(ex_rs1, st);
            s2 = m_sel(ex_rs2, st);
            $display("rnd %0d: v=%0d rs=%0d,%0d rd=%0d ld=%0d c1=%b c2=%b stall=%0d",
                     n, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
                     cntrl_sign1, cntrl_sign2, stall);
            chk("rnd_stall", stall, st);
            chk("rnd_c1", cntrl_sign1, s1);
            chk("rnd_c2", cntrl_sign2, s2);
            chk("rnd_f1", fwd_val1, m_val(s1));
            chk("rnd_f2", fwd_val2, m_val(s2));
            chk("rnd_mre", mem_rd_en, exm_m.v && exm_m.ld);
            chk("rnd_wbwe", wb_reg_write, mwb_m.v && mwb_m.we);
            chk("rnd_cnt", stall_count, cnt_m);
            if (exm_m.v) chk("rnd_maddr", mem_addr, exm_m.val);
            if (mwb_m.v) begin
                chk("rnd_wbrd", wb_rd, mwb_m.rd);
                chk("rnd_wbd", wb_data, mwb_m.val);
            end
            @(posedge clk);
            m_clock(st);
            hold = st;
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
